// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks one MEM-stage event by fixed priority,
// pulses the exception code to CP0, flushes the pipeline, then redirects the PC.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic        mem_ri_i,
    input  logic        mem_syscall_i,
    input  logic        mem_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [31:0] exc_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_delayslot_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] CODE_INT  = 32'h1;
    localparam logic [31:0] CODE_RI   = 32'ha;
    localparam logic [31:0] CODE_SYS  = 32'h8;
    localparam logic [31:0] CODE_ERET = 32'he;
    localparam logic [3:0]  CNT_LOAD  = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] target;
    logic [31:0] code;
    logic        int_pend;
    logic        accept;

    // Status/Cause bits outside IE, EXL and the IM/IP fields play no part here.
    logic unused_cp0_bits;
    assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                               cp0_cause_i[31:16], cp0_cause_i[7:0]};

    assign int_pend = cp0_status_i[0] & ~cp0_status_i[1]
                    & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        code = 32'd0;
        if (mem_valid_i) begin
            if (int_pend)           code = CODE_INT;
            else if (mem_ri_i)      code = CODE_RI;
            else if (mem_syscall_i) code = CODE_SYS;
            else if (mem_eret_i)    code = CODE_ERET;
        end
    end

    assign accept = (state == IDLE) && (code != 32'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = FLUSH;
                    cnt_n   = CNT_LOAD;
                end
            end
            FLUSH: begin
                if (cnt == 4'd0) state_n = REDIRECT;
                else             cnt_n   = cnt - 4'd1;
            end
            REDIRECT: state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            target          <= 32'd0;
            exc_o           <= 32'd0;
            exc_pc_o        <= 32'd0;
            exc_delayslot_o <= 1'b0;
            flush_o         <= 1'b0;
            redirect_o      <= 1'b0;
            redirect_pc_o   <= 32'd0;
            busy_o          <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            exc_o  <= accept ? code : 32'd0;
            if (accept) begin
                exc_pc_o        <= mem_pc_i;
                exc_delayslot_o <= mem_in_delayslot_i;
                // EPC is latched now because CP0 may overwrite it next cycle.
                target          <= (code == CODE_ERET) ? cp0_epc_i : EXC_VECTOR;
            end
            // Status outputs are registered from the next state to keep inputs off output paths.
            flush_o       <= (state_n != IDLE);
            busy_o        <= (state_n != IDLE);
            redirect_o    <= (state_n == REDIRECT);
            redirect_pc_o <= (state_n == REDIRECT) ? target : 32'd0;
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios then random traffic,
// compared every cycle against an event-timeline reference model.
module tb_exc_ctrl;

    localparam int          F   = 2;
    localparam logic [31:0] VEC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i, mem_in_delayslot_i, mem_ri_i, mem_syscall_i, mem_eret_i;
    logic [31:0] mem_pc_i, cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic [31:0] exc_o, exc_pc_o, redirect_pc_o;
    logic        exc_delayslot_o, flush_o, redirect_o, busy_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: d = cycle number since the accepting edge (0 = idle).
    int          d;
    logic [31:0] m_code, m_pc, m_target;
    logic        m_ds;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
        .mem_in_delayslot_i(mem_in_delayslot_i), .mem_ri_i(mem_ri_i),
        .mem_syscall_i(mem_syscall_i), .mem_eret_i(mem_eret_i),
        .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
        .exc_o(exc_o), .exc_pc_o(exc_pc_o), .exc_delayslot_o(exc_delayslot_o),
        .flush_o(flush_o), .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] event_code();
        logic ip;
        ip = cp0_status_i[0] && !cp0_status_i[1]
             && ((cp0_cause_i[15:8] & cp0_status_i[15:8]) != 8'h00);
        if (!mem_valid_i)       return 32'h0;
        if (ip)                 return 32'h1;
        if (mem_ri_i)           return 32'ha;
        if (mem_syscall_i)      return 32'h8;
        if (mem_eret_i)         return 32'he;
        return 32'h0;
    endfunction

    task automatic model_edge();
        logic [31:0] c;
        c = event_code();
        if (rst) begin
            d = 0; m_code = 0; m_pc = 0; m_ds = 0; m_target = 0;
        end else if (d == 0 && c != 0) begin
            d        = 1;
            m_code   = c;
            m_pc     = mem_pc_i;
            m_ds     = mem_in_delayslot_i;
            m_target = (c == 32'he) ? cp0_epc_i : VEC;
        end else if (d != 0) begin
            d = (d == F + 1) ? 0 : d + 1;
        end
    endtask

    task automatic compare_all();
        logic act, redir;
        act   = (d >= 1) && (d <= F + 1);
        redir = (d == F + 1);
        check("exc",       exc_o,           (d == 1) ? m_code : 32'h0);
        check("exc_pc",    exc_pc_o,        m_pc);
        check("delayslot", 32'(exc_delayslot_o), 32'(m_ds));
        check("flush",     32'(flush_o),    32'(act));
        check("busy",      32'(busy_o),     32'(act));
        check("redirect",  32'(redirect_o), 32'(redir));
        check("redir_pc",  redirect_pc_o,   redir ? m_target : 32'h0);
    endtask

    // Inputs are changed only at negedge; the model samples them at posedge like the DUT.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic quiet();
        mem_valid_i = 0; mem_ri_i = 0; mem_syscall_i = 0; mem_eret_i = 0;
        mem_in_delayslot_i = 0;
    endtask

    initial begin
        d = 0; m_code = 0; m_pc = 0; m_ds = 0; m_target = 0;
        rst = 1; quiet();
        mem_pc_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
        @(negedge clk);
        repeat (3) cycle();
        rst = 0;

        // Syscall after reset.
        mem_valid_i = 1; mem_syscall_i = 1; mem_pc_i = 32'hbfc00100;
        cycle();
        quiet();
        check("sys_code", exc_o, 32'h8);
        repeat (2) cycle();
        check("sys_redirect_pc", redirect_pc_o, 32'h40);
        repeat (2) cycle();

        // eret with EPC changing one cycle after acceptance.
        cp0_epc_i = 32'h00001234; mem_valid_i = 1; mem_eret_i = 1;
        cycle();
        quiet(); cp0_epc_i = 32'hdead0000;
        check("eret_code", exc_o, 32'he);
        repeat (2) cycle();
        check("eret_redirect_pc", redirect_pc_o, 32'h00001234);
        repeat (2) cycle();

        // Interrupt beats RI and syscall in the same cycle.
        cp0_status_i = 32'h0000ff01; cp0_cause_i = 32'h00000400;
        mem_valid_i = 1; mem_ri_i = 1; mem_syscall_i = 1;
        cycle();
        quiet(); cp0_status_i = 0; cp0_cause_i = 0;
        check("prio_code", exc_o, 32'h1);
        repeat (5) cycle();

        // Masking: no valid instruction, then EXL set, then RI in a delay slot.
        mem_ri_i = 1; cycle(); cycle();
        quiet();
        cp0_status_i = 32'h0000ff03; cp0_cause_i = 32'h00000400; mem_valid_i = 1;
        cycle(); cycle();
        cp0_status_i = 0; cp0_cause_i = 0;
        mem_ri_i = 1; mem_in_delayslot_i = 1; mem_pc_i = 32'h204;
        cycle();
        quiet();
        check("ri_ds_code", exc_o, 32'ha);
        check("ri_ds_pc", exc_pc_o, 32'h204);
        repeat (4) cycle();

        // Second syscall while busy, then reset in the first FLUSH cycle.
        mem_valid_i = 1; mem_syscall_i = 1; mem_pc_i = 32'h300;
        cycle(); cycle(); cycle();
        quiet(); repeat (3) cycle();
        mem_valid_i = 1; mem_syscall_i = 1; mem_pc_i = 32'h400;
        cycle();
        quiet(); rst = 1;
        cycle();
        rst = 0;
        repeat (4) cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst                = ($urandom_range(0, 99) == 0);
            mem_valid_i        = ($urandom_range(0, 3) != 0);
            mem_ri_i           = ($urandom_range(0, 5) == 0);
            mem_syscall_i      = ($urandom_range(0, 5) == 0);
            mem_eret_i         = ($urandom_range(0, 5) == 0);
            mem_in_delayslot_i = 1'($urandom);
            mem_pc_i           = $urandom;
            cp0_epc_i          = $urandom;
            cp0_status_i       = $urandom;
            cp0_cause_i        = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer between the MEM stage and the CP0 register file. It samples the exception flags of the instruction in MEM and the pending-interrupt state from CP0, and picks one event by fixed priority. It drives the one-cycle exception code that CP0 consumes, flushes the pipeline for a programmable number of cycles, and then issues a single PC redirect to the exception vector or to EPC.

## Interface
- `EXC_VECTOR`, default 32'h00000040: redirect target for interrupt, reserved-instruction and syscall.
- `FLUSH_CYCLES`, default 2: number of cycles `flush_o` is held; legal range 1..15.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `mem_valid_i` in 1: MEM stage holds a real (non-bubble) instruction.
- `mem_pc_i` in 32: PC of the MEM instruction.
- `mem_in_delayslot_i` in 1: MEM instruction is in a branch delay slot.
- `mem_ri_i` in 1: reserved-instruction flag.
- `mem_syscall_i` in 1: syscall flag.
- `mem_eret_i` in 1: eret flag.
- `cp0_status_i` in 32: current CP0 Status.
- `cp0_cause_i` in 32: current CP0 Cause.
- `cp0_epc_i` in 32: current CP0 EPC.
- `exc_o` out 32: exception code to CP0; nonzero for exactly one cycle per event.
- `exc_pc_o` out 32: faulting instruction address to CP0.
- `exc_delayslot_o` out 1: delay-slot flag to CP0.
- `flush_o` out 1: flush all pipeline stages up to and including MEM.
- `redirect_o` out 1: one-cycle PC load strobe.
- `redirect_pc_o` out 32: PC load value, valid while `redirect_o` is 1.
- `busy_o` out 1: high whenever state is not IDLE.

## Operation
- Interrupt pending:
  - `int_pend = cp0_status_i[0] & ~cp0_status_i[1] & |(cp0_cause_i[15:8] & cp0_status_i[15:8])`.
- Event acceptance:
  - Events are sampled only in IDLE, and only when `mem_valid_i`=1; with `mem_valid_i`=0, all flags and `int_pend` are ignored.
  - Priority when several are true: interrupt > RI > syscall > eret. The lower-priority events are dropped, not queued.
- Codes on `exc_o`: interrupt 32'h1, RI 32'ha, syscall 32'h8, eret 32'he; 0 otherwise.
- On the accepting edge the block registers:
  - code into `exc_o`;
  - `mem_pc_i` into `exc_pc_o`;
  - `mem_in_delayslot_i` into `exc_delayslot_o`;
  - target into an internal register: `cp0_epc_i` for eret, `EXC_VECTOR` otherwise. EPC is captured before CP0 can change it.
- FSM:
  - IDLE: on accept, go to FLUSH and load the down-counter with `FLUSH_CYCLES-1`; otherwise stay.
  - FLUSH: `flush_o`=1. The counter decrements each edge; on the edge where the counter is 0, go to REDIRECT.
  - REDIRECT: `flush_o`=1, `redirect_o`=1, `redirect_pc_o`=target. The next edge goes to IDLE. No acceptance occurs on that edge.
- While not IDLE, all MEM flags and interrupts are ignored. An interrupt that is still pending is taken later, on a valid instruction.
- `exc_o` returns to 0 on the edge after it was set, regardless of state.
- Counter width is 4 bits; no wrap occurs, because the counter only decrements in FLUSH and leaves FLUSH at 0.

## Timing
- Reset value of every output: `exc_o`=0, `exc_pc_o`=0, `exc_delayslot_o`=0, `flush_o`=0, `redirect_o`=0, `redirect_pc_o`=0, `busy_o`=0; state IDLE; counter 0.
- `rst` high at any edge, including mid-FLUSH or in REDIRECT, forces the reset values at that edge. No redirect is issued afterwards.
- Accept at edge E0. `exc_o`, `flush_o` and `busy_o` are high in the cycle after E0.
  - `flush_o` is high for `FLUSH_CYCLES` cycles in FLUSH plus 1 cycle in REDIRECT.
  - `redirect_o` is high in cycle `FLUSH_CYCLES`+1 after E0.
- Earliest next acceptance: edge E0+`FLUSH_CYCLES`+2.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset and syscall:
  - Stimulus: reset 3 cycles, then `mem_valid_i`=1, `mem_syscall_i`=1, `mem_pc_i`=32'hbfc00100, delay slot 0, `FLUSH_CYCLES`=2.
  - Required: `exc_o`=32'h8 and `exc_pc_o`=32'hbfc00100 for one cycle; `flush_o` high 3 cycles; `redirect_o` in cycle 3 with `redirect_pc_o`=32'h40; `busy_o` low again in cycle 4.
- eret:
  - Stimulus: `cp0_epc_i`=32'h00001234 and `mem_eret_i`=1. EPC is changed to 32'hdead0000 one cycle later.
  - Required: `exc_o`=32'he; `redirect_pc_o`=32'h00001234.
- Priority:
  - Stimulus: Status=32'h0000ff01, Cause[15:8]=8'h04, `mem_syscall_i`=1 and `mem_ri_i`=1 in the same cycle.
  - Required: `exc_o`=32'h1 only; no second event follows.
- Masking and delay slot:
  - Stimulus: `mem_valid_i`=0 with RI asserted; then Status EXL=1 with an interrupt pending; then RI with `mem_in_delayslot_i`=1 and PC 32'h204.
  - Required: no response to the first two; the third gives `exc_o`=32'ha, `exc_delayslot_o`=1, `exc_pc_o`=32'h204.
- Busy ignore and reset mid-operation:
  - Stimulus: a second syscall during FLUSH; then, on a separate event, `rst` pulsed in the first FLUSH cycle.
  - Required: the second syscall produces no second `exc_o` pulse. After the reset pulse, all outputs are 0 and no `redirect_o` appears.
